// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
module pipe_skid_stage #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              stall_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                main_valid_r;
    logic                main_valid_s;
    logic [CTRL_W-1:0]   main_ctrl_r;
    logic [CTRL_W-1:0]   main_ctrl_s;
    logic [DATA_W-1:0]   main_data_r;
    logic [DATA_W-1:0]   main_data_s;
    logic                skid_valid_r;
    logic                skid_valid_s;
    logic [CTRL_W-1:0]   skid_ctrl_r;
    logic [CTRL_W-1:0]   skid_ctrl_s;
    logic [DATA_W-1:0]   skid_data_r;
    logic [DATA_W-1:0]   skid_data_s;
    logic                in_ready_r;
    logic [CNT_W-1:0]    stall_cnt_r;
    logic                in_fire_s;
    logic                out_fire_s;

    // Handshake qualifiers; in_ready comes straight from a flop, never from out_ready
    always_comb begin
        in_fire_s  = in_valid & in_ready_r;
        out_fire_s = main_valid_r & out_ready;
    end

    // Next-state and next-entry logic; flush overrides every handshake
    always_comb begin
        state_s      = state_r;
        main_valid_s = main_valid_r;
        main_ctrl_s  = main_ctrl_r;
        main_data_s  = main_data_r;
        skid_valid_s = skid_valid_r;
        skid_ctrl_s  = skid_ctrl_r;
        skid_data_s  = skid_data_r;
        if (flush) begin
            // Payload is left in place; only valid and control are killed
            state_s      = ST_EMPTY;
            main_valid_s = 1'b0;
            main_ctrl_s  = {CTRL_W{1'b0}};
            skid_valid_s = 1'b0;
            skid_ctrl_s  = {CTRL_W{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_s      = ST_ONE;
                        main_valid_s = 1'b1;
                        main_ctrl_s  = in_ctrl;
                        main_data_s  = in_data;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        state_s      = ST_ONE;
                        main_valid_s = 1'b1;
                        main_ctrl_s  = in_ctrl;
                        main_data_s  = in_data;
                    end else if (in_fire_s) begin
                        state_s      = ST_FULL;
                        skid_valid_s = 1'b1;
                        skid_ctrl_s  = in_ctrl;
                        skid_data_s  = in_data;
                    end else if (out_fire_s) begin
                        state_s      = ST_EMPTY;
                        main_valid_s = 1'b0;
                        main_ctrl_s  = {CTRL_W{1'b0}};
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // Skid entry is older than anything upstream, so it moves up first
                    if (out_fire_s) begin
                        state_s      = ST_ONE;
                        main_valid_s = 1'b1;
                        main_ctrl_s  = skid_ctrl_r;
                        main_data_s  = skid_data_r;
                        skid_valid_s = 1'b0;
                        skid_ctrl_s  = {CTRL_W{1'b0}};
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s      = ST_EMPTY;
                    main_valid_s = 1'b0;
                    main_ctrl_s  = {CTRL_W{1'b0}};
                    skid_valid_s = 1'b0;
                    skid_ctrl_s  = {CTRL_W{1'b0}};
                end
            endcase
        end
    end

    // State and entry registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_EMPTY;
            main_valid_r <= 1'b0;
            main_ctrl_r  <= {CTRL_W{1'b0}};
            main_data_r  <= {DATA_W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_ctrl_r  <= {CTRL_W{1'b0}};
            skid_data_r  <= {DATA_W{1'b0}};
            in_ready_r   <= 1'b1;
        end else begin
            state_r      <= state_s;
            main_valid_r <= main_valid_s;
            main_ctrl_r  <= main_ctrl_s;
            main_data_r  <= main_data_s;
            skid_valid_r <= skid_valid_s;
            skid_ctrl_r  <= skid_ctrl_s;
            skid_data_r  <= skid_data_s;
            in_ready_r   <= ~skid_valid_s;
        end
    end

    // Saturating stall counter; clear wins over increment, flush is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_clr) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (main_valid_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_ctrl  = main_ctrl_r;
    assign out_data  = main_data_r;
    assign occupancy = state_r;
    assign stall_cnt = stall_cnt_r;

endmodule
